// File: rtl/rgf_pkg.sv
// Shared constants and types for the register-file dump streamer.
// Optional checksum word is enabled by defining RGF_DUMP_CHECKSUM_EN.
package rgf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int XLEN      = 32;
  localparam int RGF_IDX_W = 5;
  localparam int SNAP_W    = NUM_REGS * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    SUM  = 2'd2
  } rgf_dump_state_t;

  // Select one XLEN-bit word out of a flattened snapshot.
  function automatic logic [XLEN-1:0] snap_word(input logic [SNAP_W-1:0]    snap,
                                                input logic [RGF_IDX_W-1:0] idx);
    return snap[int'(idx)*XLEN +: XLEN];
  endfunction

endpackage

// File: rtl/rgf_dump_streamer.sv
// Register-file snapshot streamer: captures the flattened 32x32 state in one
// cycle on start, then emits r0..r31 over valid/ready. With RGF_DUMP_CHECKSUM_EN
// defined, a 33rd word carries the XOR of all captured words.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a dump
// SEND  | presenting snapshot word[cnt_q]
// SUM   | presenting the XOR checksum (checksum build only)
module rgf_dump_streamer
  import rgf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SNAP_W-1:0]    snap_in,
  output logic                 busy,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [XLEN-1:0]      m_data,
  output logic [RGF_IDX_W-1:0] m_index,
  output logic                 m_is_sum,
  output logic                 m_last,
  output logic                 done
);

  localparam logic [RGF_IDX_W-1:0] LAST_IDX = RGF_IDX_W'(NUM_REGS - 1);

  rgf_dump_state_t      state_q, state_d;
  logic [RGF_IDX_W-1:0] cnt_q, cnt_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic                 done_q, done_d;
  logic                 hs;

  assign hs   = m_valid & m_ready;
  assign done = done_q;

`ifdef RGF_DUMP_CHECKSUM_EN
  logic [XLEN-1:0] sum;

  // XOR fold of the frozen snapshot, presented as the trailing checksum word.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sum = sum ^ snap_q[i*XLEN +: XLEN];
    end
  end
`endif

  // Control state, word counter and done pulse; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Snapshot storage; only written on an accepted start, so no reset needed.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    done_d   = 1'b0;
    busy     = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_index  = '0;
    m_is_sum = 1'b0;
    m_last   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = snap_in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = snap_word(snap_q, cnt_q);
        m_index = cnt_q;
`ifndef RGF_DUMP_CHECKSUM_EN
        m_last  = (cnt_q == LAST_IDX);
`endif
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
`ifdef RGF_DUMP_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef RGF_DUMP_CHECKSUM_EN
      SUM: begin
        busy     = 1'b1;
        m_valid  = 1'b1;
        m_data   = sum;
        m_is_sum = 1'b1;
        m_last   = 1'b1;
        if (hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rgf_dump_streamer.sv
module tb_rgf_dump_streamer;

`ifdef RGF_DUMP_CHECKSUM_EN
  localparam int NWORDS = 33;
`else
  localparam int NWORDS = 32;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] snap_in = '0;
  logic          busy;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [31:0]   m_data;
  logic [4:0]    m_index;
  logic          m_is_sum;
  logic          m_last;
  logic          done;

  rgf_dump_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .snap_in  (snap_in),
    .busy     (busy),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_is_sum (m_is_sum),
    .m_last   (m_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          idx;
    logic        is_sum;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   ready_mode = 0;
  int   rp = 0;

  // Expected stream for one dump of snapshot s.
  task automatic push_dump(input logic [1023:0] s);
    exp_t e;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 32; i++) begin
      e.data   = s[i*32 +: 32];
      e.idx    = i;
      e.is_sum = 1'b0;
      e.last   = (NWORDS == 32) && (i == 31);
      x        = x ^ e.data;
      sb.push_back(e);
    end
    if (NWORDS == 33) begin
      e.data   = x;
      e.idx    = 0;
      e.is_sum = 1'b1;
      e.last   = 1'b1;
      sb.push_back(e);
    end
  endtask

  // m_ready driver: constant 1, or the 1,0,0 repeating pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rp++;
      if (ready_mode == 0) m_ready = 1'b1;
      else                 m_ready = (rp % 3 == 0);
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic        pv = 1'b0, pr = 1'b0, ps = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [4:0]  pi = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (pv && !pr) begin
        n_checks++;
        if ({m_valid, m_data, m_index, m_is_sum, m_last} !== {1'b1, pd, pi, ps, pl}) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b d=%h i=%0d s=%0b l=%0b, required v=1 d=%h i=%0d s=%0b l=%0b",
                   m_valid, m_data, m_index, m_is_sum, m_last, pd, pi, ps, pl);
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got d=%h i=%0d, required no transfer", m_data, m_index);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_data !== e.data || m_index !== 5'(e.idx) || m_is_sum !== e.is_sum || m_last !== e.last) begin
            n_fail++;
            $display("FAIL word: got d=%h i=%0d s=%0b l=%0b, required d=%h i=%0d s=%0b l=%0b",
                     m_data, m_index, m_is_sum, m_last, e.data, e.idx, e.is_sum, e.last);
          end
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pi = m_index; ps = m_is_sum; pl = m_last;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int k = 0; k < max; k++) begin
      tick();
      if (done) begin
        at = edge_n;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got no done in %0d cycles, required done", max);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_flushed(input string name);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  logic [1023:0] s;
  int at;

  initial begin
    // Reset values.
    reset = 1'b0;
    tick(); tick(); tick();
    check("reset_outputs", {26'd0, busy, m_valid, m_data, m_index, m_is_sum, m_last, done}, 64'd0);
    reset = 1'b1;

    // r[i] = 0x0100_0000 + i, ready held, start sampled at edge 10.
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = 32'h0100_0000 + 32'(i);
    snap_in = s;
    push_dump(s);
    while (edge_n < 9) tick();
    start_pulse();
    check("first_word_latency", {61'd0, m_valid, busy, (m_index == 5'd0)}, 64'd7);
    wait_done(100, at);
    check("done_cycle", 64'(at), 64'(10 + NWORDS));
    check("done_idle_valid", {63'd0, m_valid}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check_flushed("dump1_complete");

    // Ready toggling 1,0,0 with distinct words.
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = (32'(i) * 32'h1111_1111) ^ 32'hA5A5_0F0F;
    snap_in = s;
    push_dump(s);
    ready_mode = 1;
    start_pulse();
    wait_done(200, at);
    ready_mode = 0;
    tick();
    check_flushed("stall_dump_complete");

    // Checksum pattern: only r5 non-zero.
    s = '0;
    s[5*32 +: 32] = 32'hDEAD_BEEF;
    snap_in = s;
    push_dump(s);
    start_pulse();
    wait_done(100, at);
    check("sum_done_cycle", 64'(at), 64'(edge_n));
    tick();
    check_flushed("sum_dump_complete");

    // Snapshot frozen; start ignored while busy.
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = 32'h5000_0000 | (32'(i) << 4);
    snap_in = s;
    push_dump(s);
    start_pulse();
    snap_in = '1;
    tick(); tick(); tick();
    start_pulse();
    tick();
    check("busy_mid_dump", {63'd0, busy}, 64'd1);
    wait_done(100, at);
    tick();
    check("no_restart_after_busy_start", {63'd0, m_valid}, 64'd0);
    check_flushed("frozen_dump_complete");

    // Reset mid-dump at word 12.
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = 32'hC000_0000 + 32'(i * 3);
    snap_in = s;
    push_dump(s);
    start_pulse();
    for (int k = 0; k < 50 && !(m_valid && m_index == 5'd12); k++) tick();
    check("reached_word12", {63'd0, (m_valid && m_index == 5'd12)}, 64'd1);
    reset = 1'b0;
    tick();
    check("midreset_outputs", {26'd0, busy, m_valid, m_data, m_index, m_is_sum, m_last, done}, 64'd0);
    reset = 1'b1;
    tick();
    check("midreset_no_done", {62'd0, done, m_valid}, 64'd0);
    sb.delete();
    push_dump(s);
    start_pulse();
    check("restream_index0", {62'd0, m_valid, (m_index == 5'd0)}, 64'd3);
    wait_done(100, at);
    tick();
    check_flushed("restream_complete");

    // start held high: back-to-back dumps.
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = ~(32'h0000_1000 * 32'(i + 1));
    snap_in = s;
    push_dump(s);
    push_dump(s);
    start = 1'b1;
    tick();
    wait_done(100, at);
    check("held_done_cycle_idle", {62'd0, done, m_valid}, 64'd2);
    tick();
    start = 1'b0;
    check("held_second_start", {61'd0, m_valid, busy, (m_index == 5'd0)}, 64'd7);
    wait_done(100, at);
    tick();
    check("held_single_restart", {63'd0, m_valid}, 64'd0);
    check_flushed("held_dumps_complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
